// File: rtl/memory_pkg.sv
// Shared scratchpad constants and index types for the banked memory path.
package memory_pkg;
  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_BANKS  = 4;
  localparam int BANK_BITS  = $clog2(NUM_BANKS);

  typedef logic [BANK_BITS-1:0] bank_idx_t;
endpackage

// File: rtl/bank_request_router_addr_xlate.sv
// AddressTranslation: low address bits pick the bank, the rest is the in-bank word address.
module AddressTranslation
  import memory_pkg::*;
#(
  parameter  int ADDR_W = ADDR_WIDTH,
  parameter  int NB     = NUM_BANKS,
  localparam int BB     = $clog2(NB)
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [BB-1:0]     bank_sel_o,
  output logic [ADDR_W-1:0] local_addr_o
);
  assign bank_sel_o   = addr_i[BB-1:0];
  // Upper bits pass through untouched; the SRAM wrapper truncates to its depth.
  assign local_addr_o = addr_i >> BB;
endmodule

// File: rtl/bank_request_router_rr_arbiter.sv
// rr_arbiter: round-robin grant over N requesters, pointer moves past the winner on advance.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);
  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  int            k;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr_q) + i) % N;
      if (!found && req[k]) begin
        found     = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = IW'(k);
      end
    end
    ptr_d = ptr_q;
    if (advance && found) ptr_d = IW'((int'(grant_idx) + 1) % N);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/bank_request_router.sv
// Routes NP requesters onto NB single-port SRAM banks with per-bank round-robin and 2-cycle reads.
// Optional BANK_CONFLICT_STATS_EN adds saturating per-bank contention counters (conflict_cnt).
module bank_request_router
  import memory_pkg::*;
#(
  parameter  int NUM_PORTS = 2,
  parameter  int ADDR_W    = ADDR_WIDTH,
  parameter  int DATA_W    = DATA_WIDTH,
  parameter  int NB        = NUM_BANKS,
  localparam int NP        = NUM_PORTS,
  localparam int BB        = $clog2(NB),
  localparam int PW        = (NP > 1) ? $clog2(NP) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NP-1:0]                req_valid,
  output logic [NP-1:0]                req_ready,
  input  logic [NP-1:0]                req_we,
  input  logic [NP-1:0][ADDR_W-1:0]    req_addr,
  input  logic [NP-1:0][DATA_W-1:0]    req_wdata,
  output logic [NP-1:0]                rsp_valid,
  output logic [NP-1:0][DATA_W-1:0]    rsp_rdata,
  output logic [NB-1:0]                bank_en,
  output logic [NB-1:0]                bank_we,
  output logic [NB-1:0][ADDR_W-1:0]    bank_addr,
  output logic [NB-1:0][DATA_W-1:0]    bank_wdata,
  input  logic [NB-1:0][DATA_W-1:0]    bank_rdata
`ifdef BANK_CONFLICT_STATS_EN
  , output logic [NB-1:0][31:0]        conflict_cnt
`endif
);
  typedef logic [PW-1:0] port_idx_t;

  logic [NP-1:0][BB-1:0]     bank_sel;
  logic [NP-1:0][ADDR_W-1:0] local_addr;
  logic [NB-1:0][NP-1:0]     cand_raw, cand, grant;
  port_idx_t [NB-1:0]        gidx;

  logic [NB-1:0]             bank_en_q, bank_en_d, bank_we_q, bank_we_d;
  logic [NB-1:0][ADDR_W-1:0] bank_addr_q, bank_addr_d;
  logic [NB-1:0][DATA_W-1:0] bank_wdata_q, bank_wdata_d;
  port_idx_t [NB-1:0]        pid1_q, pid1_d, rpid_q;
  logic [NB-1:0]             rd_vld_q;
  logic [NP-1:0][DATA_W-1:0] rdata_hold_q;

  for (genvar p = 0; p < NP; p++) begin : g_port
    AddressTranslation #(.ADDR_W(ADDR_W), .NB(NB)) u_xlate (
      .addr_i      (req_addr[p]),
      .bank_sel_o  (bank_sel[p]),
      .local_addr_o(local_addr[p])
    );
  end

  // Grants are suppressed while reset is asserted so nothing handshakes during reset.
  always_comb begin
    cand_raw = '0;
    cand     = '0;
    for (int b = 0; b < NB; b++)
      for (int p = 0; p < NP; p++) begin
        cand_raw[b][p] = req_valid[p] && (bank_sel[p] == BB'(b));
        cand[b][p]     = cand_raw[b][p] && rst_n;
      end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    rr_arbiter #(.N(NP)) u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (cand[b]),
      .advance  (|cand[b]),
      .grant    (grant[b]),
      .grant_idx(gidx[b])
    );
  end

  always_comb begin
    req_ready    = '0;
    bank_en_d    = '0;
    bank_we_d    = '0;
    bank_addr_d  = bank_addr_q;
    bank_wdata_d = bank_wdata_q;
    pid1_d       = pid1_q;
    for (int b = 0; b < NB; b++) begin
      for (int p = 0; p < NP; p++) req_ready[p] = req_ready[p] | grant[b][p];
      if (|grant[b]) begin
        bank_en_d[b]    = 1'b1;
        bank_we_d[b]    = req_we[gidx[b]];
        bank_addr_d[b]  = local_addr[gidx[b]];
        bank_wdata_d[b] = req_wdata[gidx[b]];
        pid1_d[b]       = gidx[b];
      end
    end
  end

  // At most one bank can hold a read for a given port in any cycle.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = rdata_hold_q;
    for (int b = 0; b < NB; b++)
      if (rd_vld_q[b]) begin
        rsp_valid[rpid_q[b]] = 1'b1;
        rsp_rdata[rpid_q[b]] = bank_rdata[b];
      end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_en_q    <= '0;
      bank_we_q    <= '0;
      bank_addr_q  <= '0;
      bank_wdata_q <= '0;
      pid1_q       <= '0;
      rpid_q       <= '0;
      rd_vld_q     <= '0;
      rdata_hold_q <= '0;
    end else begin
      bank_en_q    <= bank_en_d;
      bank_we_q    <= bank_we_d;
      bank_addr_q  <= bank_addr_d;
      bank_wdata_q <= bank_wdata_d;
      pid1_q       <= pid1_d;
      rpid_q       <= pid1_q;
      rd_vld_q     <= bank_en_q & ~bank_we_q;
      rdata_hold_q <= rsp_rdata;
    end
  end

  assign bank_en    = bank_en_q;
  assign bank_we    = bank_we_q;
  assign bank_addr  = bank_addr_q;
  assign bank_wdata = bank_wdata_q;

`ifdef BANK_CONFLICT_STATS_EN
  logic [NB-1:0][31:0] cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else
      for (int b = 0; b < NB; b++)
        if ($countones(cand_raw[b]) >= 2 && cnt_q[b] != 32'hFFFF_FFFF)
          cnt_q[b] <= cnt_q[b] + 32'd1;
  end
  assign conflict_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_bank_request_router.sv
// Directed + randomized bench for bank_request_router with a transaction-level scoreboard.
module tb_bank_request_router;
  localparam int NP = 2, NB = 4, AW = 16, DW = 32;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NP-1:0]         req_valid = '0, req_we = '0, req_ready, rsp_valid;
  logic [NP-1:0][AW-1:0] req_addr = '0;
  logic [NP-1:0][DW-1:0] req_wdata = '0, rsp_rdata;
  logic [NB-1:0]         bank_en, bank_we;
  logic [NB-1:0][AW-1:0] bank_addr;
  logic [NB-1:0][DW-1:0] bank_wdata;
  logic [NB-1:0][DW-1:0] bank_rdata = '0;
`ifdef BANK_CONFLICT_STATS_EN
  logic [NB-1:0][31:0]   conflict_cnt;
`endif

  always #5 clk = ~clk;

  bank_request_router #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .NB(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
`ifdef BANK_CONFLICT_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  // SRAM banks seen by the DUT (not reset, like real memory).
  logic [DW-1:0] sram [NB][64];
  always @(posedge clk)
    for (int b = 0; b < NB; b++)
      if (bank_en[b]) begin
        if (bank_we[b]) sram[b][bank_addr[b][5:0]] <= bank_wdata[b];
        else            bank_rdata[b] <= sram[b][bank_addr[b][5:0]];
      end

  // Reference model: flat memory by global address, per-bank turn pointer, per-port response queues.
  typedef struct { int due; logic [DW-1:0] d; } rsp_t;
  int            nvec = 0, nerr = 0, cyc = 0;
  int            ptr[NB];
  logic [DW-1:0] gmem[256];
  logic          xen[NB], xwe[NB];
  logic [AW-1:0] xaddr[NB];
  logic [DW-1:0] xwd[NB];
  rsp_t          rq[NP][$];
  logic [DW-1:0] last[NP];
  longint        xcnt[NB];
  logic          post_rst = 1'b1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic st(input logic r, input logic [1:0] v, input logic [1:0] we,
                    input logic [15:0] a0, input logic [15:0] a1,
                    input logic [31:0] d0, input logic [31:0] d1);
    logic [NP-1:0] xr;
    int            win[NB];
    int            p, n;
    logic [15:0]   a[NP];
    logic [31:0]   d[NP];
    @(negedge clk);
    rst_n = r; req_valid = v; req_we = we;
    req_addr[0] = a0; req_addr[1] = a1; req_wdata[0] = d0; req_wdata[1] = d1;
    a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
    #1;
    xr = '0;
    for (int b = 0; b < NB; b++) begin
      win[b] = -1;
      if (r)
        for (int k = 0; k < NP; k++) begin
          p = (ptr[b] + k) % NP;
          if (win[b] < 0 && v[p] && (int'(a[p]) % NB) == b) win[b] = p;
        end
      if (win[b] >= 0) xr[win[b]] = 1'b1;
    end
    chk("req_ready", 64'(req_ready), 64'(xr));
    for (int b = 0; b < NB; b++) begin
      chk("bank_en", 64'(bank_en[b]), 64'(xen[b]));
      if (xen[b]) chk("bank_op", {15'd0, bank_we[b], bank_addr[b], bank_wdata[b]},
                      {15'd0, xwe[b], xaddr[b], xwd[b]});
      if (post_rst) chk("rst_bank_zero", {15'd0, bank_we[b], bank_addr[b], bank_wdata[b]}, 64'd0);
    end
    for (int q = 0; q < NP; q++) begin
      if (rq[q].size() > 0 && rq[q][0].due == cyc) begin
        chk("rsp_valid", 64'(rsp_valid[q]), 64'd1);
        chk("rsp_rdata", 64'(rsp_rdata[q]), 64'(rq[q][0].d));
        last[q] = rq[q][0].d;
        void'(rq[q].pop_front());
      end else begin
        chk("rsp_idle", 64'(rsp_valid[q]), 64'd0);
        chk("rsp_hold", 64'(rsp_rdata[q]), 64'(last[q]));
      end
    end
`ifdef BANK_CONFLICT_STATS_EN
    for (int b = 0; b < NB; b++) chk("conflict_cnt", 64'(conflict_cnt[b]), 64'(xcnt[b]));
`endif
    post_rst = 1'b0;
    for (int b = 0; b < NB; b++) begin
      n = 0;
      for (int q = 0; q < NP; q++) if (v[q] && (int'(a[q]) % NB) == b) n++;
      if (r && n >= 2 && xcnt[b] < 64'hFFFF_FFFF) xcnt[b]++;
      xen[b] = (win[b] >= 0);
      if (xen[b]) begin
        p = win[b];
        xwe[b] = we[p]; xaddr[b] = a[p] >> 2; xwd[b] = d[p];
        ptr[b] = (p + 1) % NP;
        if (we[p]) gmem[a[p][7:0]] = d[p];
        else       rq[p].push_back('{cyc + 2, gmem[a[p][7:0]]});
      end
    end
    if (!r) begin
      for (int b = 0; b < NB; b++) begin ptr[b] = 0; xen[b] = 1'b0; xcnt[b] = 0; end
      for (int q = 0; q < NP; q++) begin rq[q].delete(); last[q] = '0; end
      post_rst = 1'b1;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) st(1'b1, 2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 32'h0);
  endtask

  initial begin
    for (int b = 0; b < NB; b++) begin
      for (int i = 0; i < 64; i++) sram[b][i] = '0;
      ptr[b] = 0; xen[b] = 1'b0; xwe[b] = 1'b0; xaddr[b] = '0; xwd[b] = '0; xcnt[b] = 0;
    end
    for (int i = 0; i < 256; i++) gmem[i] = '0;
    for (int q = 0; q < NP; q++) last[q] = '0;
    repeat (2) @(posedge clk);

    // Write then read back through bank 1.
    st(1'b1, 2'b01, 2'b01, 16'h0005, 16'h0, 32'hDEADBEEF, 32'h0);
    st(1'b1, 2'b01, 2'b00, 16'h0005, 16'h0, 32'h0, 32'h0);
    idle(3);
    // Two ports, two banks, same cycle.
    st(1'b1, 2'b11, 2'b00, 16'h0004, 16'h0007, 32'h0, 32'h0);
    idle(3);
    // Seed bank 2, reset, then both ports contend for bank 2.
    st(1'b1, 2'b01, 2'b01, 16'h0002, 16'h0, 32'h2222_0002, 32'h0);
    st(1'b1, 2'b10, 2'b10, 16'h0, 16'h0006, 32'h0, 32'h6666_0006);
    st(1'b0, 2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) st(1'b1, 2'b11, 2'b00, 16'h0002, 16'h0006, 32'h0, 32'h0);
    idle(3);
    // Port1 fills 0..7, port0 streams them back.
    for (int i = 0; i < 8; i++) st(1'b1, 2'b10, 2'b10, 16'h0, 16'(i), 32'h0, 32'hA0 + 32'(i));
    for (int i = 0; i < 8; i++) st(1'b1, 2'b01, 2'b00, 16'(i), 16'h0, 32'h0, 32'h0);
    idle(3);
    // Reset while two reads are in flight, then a contended grant must go to port 0.
    st(1'b1, 2'b11, 2'b00, 16'h0005, 16'h0007, 32'h0, 32'h0);
    st(1'b0, 2'b11, 2'b00, 16'h0002, 16'h0006, 32'h0, 32'h0);
    st(1'b1, 2'b11, 2'b00, 16'h0002, 16'h0006, 32'h0, 32'h0);
    idle(3);
    // Read-after-write on consecutive cycles, same port.
    st(1'b1, 2'b01, 2'b01, 16'h0009, 16'h0, 32'h0000_1234, 32'h0);
    st(1'b1, 2'b01, 2'b00, 16'h0009, 16'h0, 32'h0, 32'h0);
    idle(3);
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      st(($urandom_range(0, 59) != 0), 2'($urandom), 2'($urandom),
         16'($urandom_range(0, 31)), 16'($urandom_range(0, 31)), $urandom, $urandom);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
